// File: rtl/switch_debouncer.sv
// Synchronises and whole-word debounces the raw board switches feeding the switch buffer.
// Optional build macro SWITCH_CHANGE_LATCH_EN adds a sticky change_pending flag cleared by clear_change.
module switch_debouncer #(
    parameter int WORD_W        = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WORD_W-1:0] raw_switches,
`ifdef SWITCH_CHANGE_LATCH_EN
    input  logic              clear_change,
    output logic              change_pending,
`endif
    output logic [WORD_W-1:0] switches,
    output logic              changed
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    typedef enum logic {
        STABLE = 1'b0,
        SETTLE = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0][WORD_W-1:0] sync_q;
    logic [WORD_W-1:0] sync_w;

    state_t            state, state_next;
    logic [WORD_W-1:0] candidate, candidate_next;
    logic [CNT_W-1:0]  count, count_next;
    logic [WORD_W-1:0] switches_next;
    logic              changed_next;

    // Plain flop chain; raw_switches is touched by nothing else before it.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_switches};
        end
    end

    assign sync_w = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_next     = state;
        candidate_next = candidate;
        count_next     = count;
        switches_next  = switches;
        changed_next   = 1'b0;
        case (state)
            STABLE: begin
                if (sync_w != switches) begin
                    candidate_next = sync_w;
                    count_next     = CNT_ONE;
                    state_next     = SETTLE;
                end
            end
            SETTLE: begin
                if (sync_w == switches) begin
                    count_next = '0;
                    state_next = STABLE;
                end else if (sync_w != candidate) begin
                    candidate_next = sync_w;
                    count_next     = CNT_ONE;
                end else if (count == CNT_MAX) begin
                    // Whole word moves in one edge, so the buffer never sees a mixed value.
                    switches_next = candidate;
                    changed_next  = 1'b1;
                    count_next    = '0;
                    state_next    = STABLE;
                end else begin
                    count_next = count + CNT_ONE;
                end
            end
            default: begin
                count_next = '0;
                state_next = STABLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= STABLE;
            candidate <= '0;
            count     <= '0;
            switches  <= '0;
            changed   <= 1'b0;
        end else begin
            state     <= state_next;
            candidate <= candidate_next;
            count     <= count_next;
            switches  <= switches_next;
            changed   <= changed_next;
        end
    end

`ifdef SWITCH_CHANGE_LATCH_EN
    // A commit landing on the same edge as a CPU clear must not be lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            change_pending <= 1'b0;
        end else if (changed_next) begin
            change_pending <= 1'b1;
        end else if (clear_change) begin
            change_pending <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Randomised and directed bench for switch_debouncer against a run-length reference model.
// Covers the SWITCH_CHANGE_LATCH_EN ports when that macro is defined.
module tb_switch_debouncer;

    localparam int W  = 8;
    localparam int SS = 2;
    localparam int ST = 16;
    localparam int LAT = SS + ST + 1;

    logic         clock;
    logic         reset;
    logic [W-1:0] raw_switches;
    logic [W-1:0] switches;
    logic         changed;
`ifdef SWITCH_CHANGE_LATCH_EN
    logic         clear_change;
    logic         change_pending;
`endif

    switch_debouncer #(.WORD_W(W), .SYNC_STAGES(SS), .STABLE_CYCLES(ST)) dut (
        .clock          (clock),
        .reset          (reset),
        .raw_switches   (raw_switches),
`ifdef SWITCH_CHANGE_LATCH_EN
        .clear_change   (clear_change),
        .change_pending (change_pending),
`endif
        .switches       (switches),
        .changed        (changed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: the synchronised word is raw delayed SS edges; a value commits once it
    // has been seen unchanged on ST+1 consecutive edges while differing from the output.
    logic [W-1:0] m_sync [SS];
    logic [W-1:0] m_sw;
    logic [W-1:0] m_run_val;
    int           m_run_len;
    logic         m_chg;
    logic         m_pend;
    logic         clr_drv;
    int           pulses;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic [W-1:0] raw, input logic clr);
        logic [W-1:0] s;
        if (r) begin
            for (int i = 0; i < SS; i++) m_sync[i] = '0;
            m_sw = '0; m_run_val = '0; m_run_len = 0; m_chg = 1'b0; m_pend = 1'b0;
        end else begin
            s = m_sync[SS-1];
            for (int i = SS-1; i > 0; i--) m_sync[i] = m_sync[i-1];
            m_sync[0] = raw;
            if (m_run_len > 0 && s == m_run_val) m_run_len++;
            else begin
                m_run_val = s;
                m_run_len = 1;
            end
            m_chg = 1'b0;
            if (s != m_sw && m_run_len == ST + 1) begin
                m_sw  = s;
                m_chg = 1'b1;
            end
            if (m_chg) m_pend = 1'b1;
            else if (clr) m_pend = 1'b0;
        end
    endtask

    task automatic tick(input logic r, input logic [W-1:0] raw);
        @(negedge clock);
        reset = r;
        raw_switches = raw;
`ifdef SWITCH_CHANGE_LATCH_EN
        clear_change = clr_drv;
`endif
        @(posedge clock);
        #1;
        model_edge(r, raw, clr_drv);
        chk("switches", {24'd0, switches}, {24'd0, m_sw});
        chk("changed", {31'd0, changed}, {31'd0, m_chg});
`ifdef SWITCH_CHANGE_LATCH_EN
        chk("change_pending", {31'd0, change_pending}, {31'd0, m_pend});
`endif
        if (changed) pulses++;
    endtask

    // Step raw to v and hold; the first observed pulse must land on edge LAT.
    task automatic measure(input logic [W-1:0] v, input string tag);
        int lat;
        int p0;
        lat = 0;
        p0 = pulses;
        for (int i = 1; i <= LAT + 12; i++) begin
            tick(1'b0, v);
            if (changed && lat == 0) lat = i;
        end
        chk(tag, lat, LAT);
        chk({tag, "_word"}, {24'd0, switches}, {24'd0, v});
        chk({tag, "_pulses"}, pulses - p0, 1);
    endtask

    initial begin
        logic [W-1:0] v;
        int p0;
        reset = 1'b1;
        raw_switches = '0;
        clr_drv = 1'b0;
        pulses = 0;
        model_edge(1'b1, '0, 1'b0);
`ifdef SWITCH_CHANGE_LATCH_EN
        clear_change = 1'b0;
`endif

        // Reset held with A5 present, then full latency after release.
        for (int i = 0; i < 5; i++) tick(1'b1, 8'hA5);
        chk("reset_word", {24'd0, switches}, 32'h0);
        measure(8'hA5, "reset_release_lat");

        // Clean step.
        measure(8'h00, "to_zero_lat");
        measure(8'h1E, "clean_step_lat");

        // Bounce on bit0 every 3 clocks, then rest at 01.
        measure(8'h00, "pre_bounce_lat");
        p0 = pulses;
        v = 8'h00;
        for (int i = 0; i < 30; i++) begin
            if (i % 3 == 0) v = v ^ 8'h01;
            tick(1'b0, v);
        end
        chk("bounce_pulses", pulses - p0, 0);
        chk("bounce_word", {24'd0, switches}, 32'h0);
        measure(8'h01, "bounce_settle_lat");

        // Short glitch returning to the committed value.
        measure(8'h00, "pre_glitch_lat");
        p0 = pulses;
        for (int i = 0; i < 6; i++) tick(1'b0, 8'h04);
        for (int i = 0; i < 30; i++) tick(1'b0, 8'h00);
        chk("glitch_pulses", pulses - p0, 0);
        chk("glitch_word", {24'd0, switches}, 32'h0);

        // Reset lands while counting (count is 10 after the 12th edge).
        for (int i = 0; i < 12; i++) tick(1'b0, 8'h1E);
        tick(1'b1, 8'h1E);
        chk("mid_settle_reset_word", {24'd0, switches}, 32'h0);
        measure(8'h1E, "post_reset_lat");

        // Randomised bouncing segments.
        for (int seg = 0; seg < 250; seg++) begin
            int len;
            v = W'($urandom);
            if ($urandom_range(0, 3) == 0) v = m_sw;
            len = $urandom_range(1, 24);
`ifdef SWITCH_CHANGE_LATCH_EN
            clr_drv = ($urandom_range(0, 7) == 0);
`endif
            for (int i = 0; i < len; i++) tick(1'b0, v);
        end
        clr_drv = 1'b0;

`ifdef SWITCH_CHANGE_LATCH_EN
        // Pending holds until cleared; clear on the commit edge loses to the set.
        measure(8'h3C, "pend_commit_lat");
        chk("pend_after_commit", {31'd0, change_pending}, 32'h1);
        for (int i = 0; i < 5; i++) tick(1'b0, 8'h3C);
        chk("pend_holds", {31'd0, change_pending}, 32'h1);
        clr_drv = 1'b1;
        tick(1'b0, 8'h3C);
        clr_drv = 1'b0;
        chk("pend_cleared", {31'd0, change_pending}, 32'h0);
        for (int i = 1; i < LAT; i++) tick(1'b0, 8'hC3);
        clr_drv = 1'b1;
        tick(1'b0, 8'hC3);
        chk("pend_set_wins_commit", {31'd0, changed}, 32'h1);
        chk("pend_set_wins", {31'd0, change_pending}, 32'h1);
        tick(1'b0, 8'hC3);
        clr_drv = 1'b0;
        chk("pend_clear_after", {31'd0, change_pending}, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
